// File: rtl/program_loader_param.sv
// Boot-time program loader. Decodes a framed byte stream from the RX FIFO
// (big-endian length header, big-endian data words, optional 8-bit sum
// trailer). Each data word is written to instruction memory. When the image
// is accepted the block hands execution to the CPU via in_execution. A
// restart request reloads without a global reset.
module program_loader_param #(
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_BYTES = 4,
    parameter bit CHECKSUM_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_enable,
    input  logic [7:0]            received_data,
    input  logic                  restart,
    output logic                  in_execution,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic [WORD_WIDTH-1:0] write_data,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int CNT_W          = 8 * COUNT_BYTES;
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    // Wide enough to hold both the header value and 2^ADDR_WIDTH without loss.
    localparam int CMP_W = ((CNT_W > ADDR_WIDTH + 1) ? CNT_W : ADDR_WIDTH + 1) + 1;
    localparam logic [CMP_W-1:0]    MAX_WORDS = CMP_W'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = 1;

    typedef enum logic [2:0] {
        ST_LOAD_COUNT,
        ST_LOAD_DATA,
        ST_LOAD_SUM,
        ST_EXEC,
        ST_ERROR
    } state_e;

    // Where the loader goes once the last data word (or an empty image) is in.
    localparam state_e ST_AFTER_DATA = CHECKSUM_EN ? ST_LOAD_SUM : ST_EXEC;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [3:0]              byte_idx_q, byte_idx_d;
    logic [ADDR_WIDTH:0]     word_idx_q, word_idx_d;
    logic [7:0]              sum_q, sum_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic                    in_exec_q, in_exec_d;
    logic                    error_q, error_d;

    // Shared decode of the incoming byte against the current framing position.
    logic [CNT_W-1:0]      count_shift;
    logic [WORD_WIDTH-1:0] word_shift;
    logic [ADDR_WIDTH:0]   word_idx_inc;
    logic                  count_last, word_last;
    logic                  count_too_big, count_zero, image_done;

    assign count_shift   = (count_q << 8) | CNT_W'(received_data);
    assign word_shift    = (word_q << 8) | WORD_WIDTH'(received_data);
    assign word_idx_inc  = word_idx_q + ONE_WORD;
    assign count_last    = (byte_idx_q == 4'(COUNT_BYTES - 1));
    assign word_last     = (byte_idx_q == 4'(BYTES_PER_WORD - 1));
    assign count_too_big = (CMP_W'(count_shift) > MAX_WORDS);
    assign count_zero    = (count_shift == '0);
    assign image_done    = (CMP_W'(word_idx_inc) == CMP_W'(count_q));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            state_q <= ST_LOAD_COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: framing progress; restart overrides everything.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state_q;
        if (restart) begin
            state_d = ST_LOAD_COUNT;
        end else if (input_enable) begin
            case (state_q)
                ST_LOAD_COUNT: begin
                    if (count_last) begin
                        if (count_too_big) begin
                            state_d = ST_ERROR;
                        end else if (count_zero) begin
                            state_d = ST_AFTER_DATA;
                        end else begin
                            state_d = ST_LOAD_DATA;
                        end
                    end
                end
                ST_LOAD_DATA: begin
                    if (word_last && image_done) begin
                        state_d = ST_AFTER_DATA;
                    end
                end
                ST_LOAD_SUM: begin
                    state_d = (received_data == sum_q) ? ST_EXEC : ST_ERROR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Output/datapath logic: byte assembly, checksum, write scheduling, flags.
    always_comb begin
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        sum_d      = sum_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        in_exec_d  = (state_q == ST_EXEC) && !restart;
        error_d    = (state_q == ST_ERROR) && !restart;
        if (restart) begin
            // The byte presented alongside restart is discarded.
            count_d    = '0;
            byte_idx_d = '0;
            word_idx_d = '0;
            sum_d      = '0;
            word_d     = '0;
        end else if (input_enable) begin
            case (state_q)
                ST_LOAD_COUNT: begin
                    count_d    = count_shift;
                    byte_idx_d = count_last ? 4'd0 : byte_idx_q + 4'd1;
                end
                ST_LOAD_DATA: begin
                    sum_d  = sum_q + received_data;
                    word_d = word_shift;
                    if (word_last) begin
                        byte_idx_d = 4'd0;
                        we_d       = 1'b1;
                        addr_d     = word_idx_q[ADDR_WIDTH-1:0];
                        data_d     = word_shift;
                        word_idx_d = word_idx_inc;
                    end else begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            sum_q      <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            in_exec_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            sum_q      <= sum_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            in_exec_q  <= in_exec_d;
            error_q    <= error_d;
        end
    end

    // A restart arriving in the strobe cycle cancels that write.
    assign write_enable  = we_q && !restart;
    assign write_address = addr_q;
    assign write_data    = data_q;
    assign in_execution  = in_exec_q;
    assign error         = error_q;
    assign words_loaded  = word_idx_q;

endmodule

// File: tb/tb_program_loader_param.sv
// Bench for program_loader_param (default parameters). An image-level model
// interprets the accepted byte stream by its position in the frame; a
// compare process checks every output each cycle, and directed sequences
// pin the model with hand-computed literals.
module tb_program_loader_param;

    localparam int WW  = 32;
    localparam int AW  = 16;
    localparam int CB  = 4;
    localparam int CK  = 1;
    localparam int BPW = WW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          input_enable = 1'b0;
    logic [7:0]    received_data = 8'h00;
    logic          restart = 1'b0;
    logic          in_execution;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [WW-1:0] write_data;
    logic          error;
    logic [AW:0]   words_loaded;

    program_loader_param #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .COUNT_BYTES(CB),
        .CHECKSUM_EN(1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_enable (input_enable),
        .received_data(received_data),
        .restart      (restart),
        .in_execution (in_execution),
        .write_enable (write_enable),
        .write_address(write_address),
        .write_data   (write_data),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- image-level model ----------------
    typedef enum {M_OPEN, M_OK, M_BAD} mstat_e;
    logic [7:0]    img[$];
    mstat_e        m_stat = M_OPEN;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [WW-1:0] exp_data = '0;
    logic [AW:0]   exp_words = '0;
    logic          exp_exec = 1'b0;
    logic          exp_err = 1'b0;

    task automatic model_reset();
        img.delete();
        m_stat    = M_OPEN;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_words = '0;
        exp_exec  = 1'b0;
        exp_err   = 1'b0;
    endtask

    function automatic longint hdr_count();
        longint v = 0;
        for (int i = 0; i < CB; i++) v = (v << 8) | longint'(img[i]);
        return v;
    endfunction

    // Outputs after one clock edge given the inputs present before it.
    task automatic model_edge(input logic en, input logic [7:0] b, input logic rs);
        int            n;
        longint        cnt;
        longint        dpos;
        logic [7:0]    s;
        logic [WW-1:0] d;
        // Accept/reject decided on an earlier edge becomes visible now.
        exp_exec = (m_stat == M_OK) && !rs;
        exp_err  = (m_stat == M_BAD) && !rs;
        exp_we   = 1'b0;
        if (rs) begin
            img.delete();
            m_stat    = M_OPEN;
            exp_words = '0;
        end else if (en && m_stat == M_OPEN) begin
            img.push_back(b);
            n = img.size();
            if (n == CB) begin
                cnt = hdr_count();
                if (cnt > (longint'(1) << AW)) m_stat = M_BAD;
                else if (cnt == 0 && CK == 0) m_stat = M_OK;
            end else if (n > CB) begin
                cnt  = hdr_count();
                dpos = longint'(n - CB);
                if (dpos <= cnt * BPW) begin
                    if (dpos % BPW == 0) begin
                        d = '0;
                        for (int k = 0; k < BPW; k++) d = (d << 8) | WW'(img[n - BPW + k]);
                        exp_we    = 1'b1;
                        exp_words = (AW + 1)'(dpos / BPW);
                        exp_addr  = AW'(dpos / BPW - 1);
                        exp_data  = d;
                    end
                    if (dpos == cnt * BPW && CK == 0) m_stat = M_OK;
                end else begin
                    s = 8'h00;
                    for (int k = CB; k < n - 1; k++) s = s + img[k];
                    m_stat = (s == b) ? M_OK : M_BAD;
                end
            end
        end
    endtask

    // ---------------- per-cycle comparison ----------------
    logic [AW+WW-1:0] wlog[$];

    always @(negedge clk) begin
        #1;
        check("write_enable", write_enable, exp_we && !restart);
        check("write_address", write_address, exp_addr);
        check("write_data", write_data, exp_data);
        check("words_loaded", words_loaded, exp_words);
        check("in_execution", in_execution, exp_exec);
        check("error", error, exp_err);
        if (write_enable) wlog.push_back({write_address, write_data});
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input logic en, input logic [7:0] b, input logic rs);
        @(negedge clk);
        input_enable  = en;
        received_data = b;
        restart       = rs;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(en, b, rs);
    endtask

    // Sends n bytes back to back, most significant byte of v first.
    task automatic send_bytes(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, v[8*(n-1-i) +: 8], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_exec", in_execution, 0);
        check("reset_error", error, 0);
        check("reset_words", words_loaded, 0);
        check("reset_data", write_data, 0);

        // 1: two-word image, checksum 0x11+..+0xDD = 0x3B8 -> 0xB8
        wlog.delete();
        send_bytes(128'h00000002_11223344_AABBCCDD_B8, 13);
        #1 check("t1_exec_after_byte_edge", in_execution, 0);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t1_exec", in_execution, 1);
        check("t1_error", error, 0);
        check("t1_words", words_loaded, 2);
        check("t1_nwrites", wlog.size(), 2);
        check("t1_write0", wlog[0], {16'h0000, 32'h11223344});
        check("t1_write1", wlog[1], {16'h0001, 32'hAABBCCDD});

        // 2: same image, wrong checksum
        cycle(1'b0, 8'h00, 1'b1);
        #1 check("t1_exec_drop", in_execution, 0);
        wlog.delete();
        send_bytes(128'h00000002_11223344_AABBCCDD_B9, 13);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t2_error", error, 1);
        check("t2_exec", in_execution, 0);
        check("t2_nwrites", wlog.size(), 2);
        check("t2_write1", wlog[1], {16'h0001, 32'hAABBCCDD});

        // 3: empty image, checksum 0
        cycle(1'b0, 8'h00, 1'b1);
        #1 check("t2_error_cleared", error, 0);
        wlog.delete();
        send_bytes(128'h00000000_00, 5);
        #1 check("t3_exec_after_byte_edge", in_execution, 0);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t3_exec", in_execution, 1);
        check("t3_nwrites", wlog.size(), 0);
        check("t3_words", words_loaded, 0);

        // 5: restart out of EXEC, one-word image, checksum 0x338 -> 0x38
        cycle(1'b0, 8'h00, 1'b1);
        #1 check("t5_exec_drop", in_execution, 0);
        send_bytes(128'h00000001_DEADBEEF_38, 9);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t5_exec", in_execution, 1);
        check("t5_nwrites", wlog.size(), 1);
        check("t5_write0", wlog[0], {16'h0000, 32'hDEADBEEF});

        // 4: count 65537 exceeds the 65536-word memory
        cycle(1'b0, 8'h00, 1'b1);
        wlog.delete();
        send_bytes(128'h00010001, 4);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t4_error", error, 1);
        send_bytes(128'h00000001_01020304_0A, 9);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t4_error_held", error, 1);
        check("t4_exec", in_execution, 0);
        check("t4_nwrites", wlog.size(), 0);
        check("t4_words", words_loaded, 0);

        // 6: reset after the 2nd byte of the second word
        cycle(1'b0, 8'h00, 1'b1);
        send_bytes(128'h00000002_01020304_AABB, 10);
        #1 check("t6_words_before", words_loaded, 1);
        check("t6_data_before", write_data, 32'h01020304);
        @(negedge clk);
        input_enable = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_async_words", words_loaded, 0);
        check("t6_async_data", write_data, 0);
        check("t6_async_we", write_enable, 0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        // checksum 0x12+0x34+0x56+0x78 = 0x114 -> 0x14
        send_bytes(128'h00000001_12345678_14, 9);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t6_exec", in_execution, 1);
        check("t6_nwrites", wlog.size(), 1);
        check("t6_write0", wlog[0], {16'h0000, 32'h12345678});

        // 7: restart in the strobe cycle cancels the write; restart beats a byte
        cycle(1'b0, 8'h00, 1'b1);
        wlog.delete();
        send_bytes(128'h00000001_01020304, 8);
        @(negedge clk);
        input_enable = 1'b0;
        restart      = 1'b1;
        #1 check("t7_we_suppressed", write_enable, 0);
        @(posedge clk);
        model_edge(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hFF, 1'b1);
        // checksum 0xAB+0xCD+0xEF+0x01 = 0x268 -> 0x68
        send_bytes(128'h00000001_ABCDEF01_68, 9);
        cycle(1'b0, 8'h00, 1'b0);
        #1 check("t7_exec", in_execution, 1);
        check("t7_nwrites", wlog.size(), 1);
        check("t7_write0", wlog[0], {16'h0000, 32'hABCDEF01});
        check("t7_words", words_loaded, 1);

        cycle(1'b0, 8'h00, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
